// File: rtl/barrel_pipe.sv
// barrel_pipe: log barrel shifter (SLL/SRL/SRA/ROR) with optional pipeline registers, valid/ready and a tag.
// Define BARREL_PIPE_FLAGS_EN to add the o_zero / o_cout result flags.
module barrel_pipe #(
  parameter int              WIDTH     = 32,
  parameter int              SHW       = $clog2(WIDTH),
  parameter logic [SHW-1:0]  PIPE_MASK = SHW'(5'b00100),
  parameter int              TAG_W     = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_Data,
  input  logic [SHW-1:0]   i_sh,
  input  logic [1:0]       i_mod,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_Data,
  output logic [TAG_W-1:0] o_tag
`ifdef BARREL_PIPE_FLAGS_EN
  ,
  output logic             o_zero,
  output logic             o_cout
`endif
);

  localparam logic [1:0] MOD_SLL = 2'b00;
  localparam logic [1:0] MOD_SRA = 2'b10;
  localparam logic [1:0] MOD_ROR = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       mode;
    logic             fill;
    logic             cout;
    logic [SHW-1:0]   sh;
    logic [TAG_W-1:0] tag;
  } stage_t;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  // SLL runs through the right-shift datapath on a bit-reversed operand, so every
  // stage only ever shifts right; cout is the last bit that stage pushed out.
  function automatic stage_t shift_stage(input stage_t b, input int k);
    stage_t           r;
    int               d;
    logic [WIDTH-1:0] low;
    r   = b;
    d   = 1 << k;
    low = b.data >> (d - 1);
    if (b.sh[k]) begin
      if (b.mode == MOD_ROR)
        r.data = (b.data >> d) | (b.data << (WIDTH - d));
      else
        r.data = (b.data >> d) | ({WIDTH{b.fill}} & ~({WIDTH{1'b1}} >> d));
      r.cout = low[0];
    end
    return r;
  endfunction

  stage_t           head;
  stage_t           tail;
  logic             tail_v;
  stage_t           stage_d [SHW];
  logic [SHW-1:0]   stage_v;
  stage_t           st_reg  [SHW];
  logic [SHW-1:0]   v_reg;
  logic [SHW-1:0]   rdy;
  logic             head_rdy;

  always_comb begin
    head      = '0;
    head.data = (i_mod == MOD_SLL) ? bit_rev(i_Data) : i_Data;
    head.mode = i_mod;
    head.fill = (i_mod == MOD_SRA) & i_Data[WIDTH-1];
    head.cout = 1'b0;
    head.sh   = i_sh;
    head.tag  = i_tag;
  end

  // Forward path: each stage either feeds the next directly or through its register.
  always_comb begin : fwd
    stage_t cur;
    logic   cur_v;
    cur   = head;
    cur_v = i_valid;
    for (int k = 0; k < SHW; k++) begin
      stage_d[k] = shift_stage(cur, k);
      stage_v[k] = cur_v;
      if (PIPE_MASK[k]) begin
        cur   = st_reg[k];
        cur_v = v_reg[k];
      end else begin
        cur = stage_d[k];
      end
    end
    tail   = cur;
    tail_v = cur_v;
  end

  // Backward ready chain; an empty register always accepts, which collapses bubbles.
  always_comb begin : bwd
    logic r;
    r = i_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      if (PIPE_MASK[k]) r = ~v_reg[k] | r;
      rdy[k] = r;
    end
    head_rdy = r;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SHW; k++) st_reg[k] <= '0;
      v_reg <= '0;
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (PIPE_MASK[k] && rdy[k]) begin
          st_reg[k] <= stage_d[k];
          v_reg[k]  <= stage_v[k];
        end
      end
    end
  end

  assign o_ready = head_rdy;
  assign o_valid = tail_v;
  assign o_Data  = (tail.mode == MOD_SLL) ? bit_rev(tail.data) : tail.data;
  assign o_tag   = tail.tag;

`ifdef BARREL_PIPE_FLAGS_EN
  // Qualified by valid so the flag is 0 in reset even though o_Data is 0 then.
  assign o_zero = tail_v & ~|o_Data;
  assign o_cout = tail.cout;
  logic unused_tail;
  assign unused_tail = ^{tail.fill, tail.sh};
`else
  logic unused_tail;
  assign unused_tail = ^{tail.fill, tail.sh, tail.cout};
`endif

endmodule

// File: tb/tb_barrel_pipe.sv
// tb_barrel_pipe: directed vectors for a combinational and a 3-stage pipelined barrel_pipe.
// Flag checks are compiled in when BARREL_PIPE_FLAGS_EN is defined.
module tb_barrel_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        c_valid, c_oready, c_ovalid, c_iready;
  logic [31:0] c_data, c_odata;
  logic [4:0]  c_sh, c_tag, c_otag;
  logic [1:0]  c_mod;
  logic        p_vin, p_oready, p_ovalid, p_iready;
  logic [31:0] p_data, p_odata;
  logic [4:0]  p_sh, p_tag, p_otag;
  logic [1:0]  p_mod;
`ifdef BARREL_PIPE_FLAGS_EN
  logic c_zero, c_cout, p_zero, p_cout;
`endif

  barrel_pipe #(.WIDTH(32), .PIPE_MASK(5'b00000), .TAG_W(5)) u_comb (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(c_valid), .o_ready(c_oready),
    .i_Data(c_data), .i_sh(c_sh), .i_mod(c_mod), .i_tag(c_tag),
    .o_valid(c_ovalid), .i_ready(c_iready), .o_Data(c_odata), .o_tag(c_otag)
`ifdef BARREL_PIPE_FLAGS_EN
    , .o_zero(c_zero), .o_cout(c_cout)
`endif
  );

  barrel_pipe #(.WIDTH(32), .PIPE_MASK(5'b10101), .TAG_W(5)) u_pipe (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(p_vin), .o_ready(p_oready),
    .i_Data(p_data), .i_sh(p_sh), .i_mod(p_mod), .i_tag(p_tag),
    .o_valid(p_ovalid), .i_ready(p_iready), .o_Data(p_odata), .o_tag(p_otag)
`ifdef BARREL_PIPE_FLAGS_EN
    , .o_zero(p_zero), .o_cout(p_cout)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  sh;
    logic [1:0]  mod;
    logic [31:0] exp;
    logic        cout;
  } vec_t;

  vec_t vec [17];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_pipe(input int idx, input logic [4:0] tag);
    p_data = vec[idx].d;
    p_sh   = vec[idx].sh;
    p_mod  = vec[idx].mod;
    p_tag  = tag;
  endtask

  // Streams vec[0..15] with tags 0..15; optional 5-cycle output stall and one input gap.
  task automatic run_stream(input int stall_at, input int gap_at, output int lat);
    int   tx, rx, first_acc, first_out;
    logic stalled;
    tx = 0; rx = 0; first_acc = -1; first_out = -1;
    for (int cyc = 0; cyc < 200 && rx < 16; cyc++) begin
      @(negedge clk);
      stalled  = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 5);
      p_iready = !stalled;
      p_vin    = (tx < 16) && (cyc != gap_at);
      drive_pipe(tx % 16, 5'(tx));
      #1;
      if (stalled) begin
        chk("stall_valid", 32'(p_ovalid), 32'd1);
        chk("stall_data", p_odata, vec[rx].exp);
        chk("stall_tag", 32'(p_otag), 32'(rx));
        if (cyc == stall_at + 4) chk("stall_ready_low", 32'(p_oready), 32'd0);
      end else if (p_ovalid) begin
        if (first_out < 0) first_out = cyc;
        $display("stream rx=%0d data=%h tag=%0d", rx, p_odata, p_otag);
        chk("stream_data", p_odata, vec[rx].exp);
        chk("stream_tag", 32'(p_otag), 32'(rx));
`ifdef BARREL_PIPE_FLAGS_EN
        chk("stream_cout", 32'(p_cout), 32'(vec[rx].cout));
        chk("stream_zero", 32'(p_zero), 32'(vec[rx].exp == 32'd0));
`endif
        rx++;
      end
      if (p_vin && p_oready) begin
        if (first_acc < 0) first_acc = cyc;
        tx++;
      end
    end
    chk("stream_count", 32'(rx), 32'd16);
    lat = first_out - first_acc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p_vin = 1'b0;
      p_iready = 1'b1;
      #1;
      chk("drain_idle", 32'(p_ovalid), 32'd0);
    end
  endtask

  initial begin
    int lat;
    vec[0]  = '{32'h80000001, 5'd1,  2'b00, 32'h00000002, 1'b1};
    vec[1]  = '{32'h80000000, 5'd31, 2'b01, 32'h00000001, 1'b0};
    vec[2]  = '{32'h80000000, 5'd4,  2'b10, 32'hF8000000, 1'b0};
    vec[3]  = '{32'h7FFFFFFF, 5'd4,  2'b10, 32'h07FFFFFF, 1'b1};
    vec[4]  = '{32'h00000001, 5'd1,  2'b11, 32'h80000000, 1'b1};
    vec[5]  = '{32'h12345678, 5'd8,  2'b11, 32'h78123456, 1'b0};
    vec[6]  = '{32'hDEADBEEF, 5'd0,  2'b00, 32'hDEADBEEF, 1'b0};
    vec[7]  = '{32'hDEADBEEF, 5'd0,  2'b10, 32'hDEADBEEF, 1'b0};
    vec[8]  = '{32'hDEADBEEF, 5'd0,  2'b11, 32'hDEADBEEF, 1'b0};
    vec[9]  = '{32'h00000001, 5'd31, 2'b00, 32'h80000000, 1'b0};
    vec[10] = '{32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF, 1'b0};
    vec[11] = '{32'hFFFFFFFF, 5'd16, 2'b01, 32'h0000FFFF, 1'b1};
    vec[12] = '{32'h80000001, 5'd31, 2'b11, 32'h00000003, 1'b0};
    vec[13] = '{32'h12345678, 5'd4,  2'b00, 32'h23456780, 1'b1};
    vec[14] = '{32'h40000000, 5'd30, 2'b10, 32'h00000001, 1'b0};
    vec[15] = '{32'h00000003, 5'd2,  2'b01, 32'h00000000, 1'b1};
    vec[16] = '{32'h00000001, 5'd0,  2'b00, 32'h00000001, 1'b0};

    c_valid = 1'b0; c_iready = 1'b0; c_data = '0; c_sh = '0; c_mod = '0; c_tag = '0;
    p_vin = 1'b0; p_iready = 1'b1; p_data = '0; p_sh = '0; p_mod = '0; p_tag = '0;

    #1;
    chk("reset_valid", 32'(p_ovalid), 32'd0);
    chk("reset_data", p_odata, 32'd0);
    chk("reset_tag", 32'(p_otag), 32'd0);
    chk("reset_ready", 32'(p_oready), 32'd1);
`ifdef BARREL_PIPE_FLAGS_EN
    chk("reset_zero", 32'(p_zero), 32'd0);
    chk("reset_cout", 32'(p_cout), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational instance: result, tag and handshake follow the inputs at once.
    for (int i = 0; i < 17; i++) begin
      c_data   = vec[i].d;
      c_sh     = vec[i].sh;
      c_mod    = vec[i].mod;
      c_tag    = 5'(i);
      c_valid  = (i != 16);
      c_iready = i[0];
      #1;
      $display("comb vec=%0d data=%h sh=%0d mod=%0d result=%h", i, c_data, c_sh, c_mod, c_odata);
      chk($sformatf("comb_data[%0d]", i), c_odata, vec[i].exp);
      chk($sformatf("comb_tag[%0d]", i), 32'(c_otag), 32'(i));
      chk($sformatf("comb_valid[%0d]", i), 32'(c_ovalid), 32'(i != 16));
      chk($sformatf("comb_ready[%0d]", i), 32'(c_oready), 32'(i[0]));
`ifdef BARREL_PIPE_FLAGS_EN
      chk($sformatf("comb_cout[%0d]", i), 32'(c_cout), 32'(vec[i].cout));
      chk($sformatf("comb_zero[%0d]", i), 32'(c_zero), 32'(vec[i].exp == 32'd0));
`endif
    end

    run_stream(-1, -1, lat);
    chk("first_latency", 32'(lat), 32'd3);
    run_stream(6, 4, lat);

    // Three operands in flight, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      p_vin = 1'b1;
      p_iready = 1'b1;
      drive_pipe(i, 5'(i));
    end
    @(posedge clk);
    #2;
    p_vin = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(p_ovalid), 32'd0);
    chk("async_rst_data", p_odata, 32'd0);
    chk("async_rst_ready", 32'(p_oready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p_vin = 1'b1;
    drive_pipe(5, 5'd21);
    #1;
    chk("post_rst_ready", 32'(p_oready), 32'd1);
    for (int w = 1; w <= 3; w++) begin
      @(negedge clk);
      p_vin = 1'b0;
      #1;
      $display("post_rst cycle=%0d valid=%0d data=%h tag=%0d", w, p_ovalid, p_odata, p_otag);
      if (w < 3) begin
        chk("post_rst_wait", 32'(p_ovalid), 32'd0);
      end else begin
        chk("post_rst_valid", 32'(p_ovalid), 32'd1);
        chk("post_rst_data", p_odata, 32'h78123456);
        chk("post_rst_tag", 32'(p_otag), 32'd21);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
